// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler feeding whole byte messages from N_REQ requesters into one UART transmitter.
// Latency: grant one cycle after a valid is seen in IDLE; strobe one cycle after a byte is accepted; 3-cycle minimum byte spacing.
// Backpressure: only the owner sees ready, equal to !tx_busy_i in GRANT; optional grant timeout under `define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic               tx_write_o,
    output logic [7:0]         tx_val_o,
    input  logic               tx_busy_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic               timeout_o
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_ptr;       // last granted index; equals the owner while a grant is held
    logic [N_REQ-1:0] r_grant;
    logic [7:0]       r_val;
    logic             r_last;
    logic             w_pick_vld;
    logic [IW-1:0]    w_pick_idx;
    logic [IW-1:0]    w_scan_idx;
    logic             w_xfer;
    logic             w_tmo;

    // Round-robin pick: scan from the index after the last owner, nearest valid requester wins
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_scan_idx = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_scan_idx = IW'((int'(r_ptr) + i) % N_REQ);
            if (req_valid_i[w_scan_idx]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_scan_idx;
            end
        end
    end

    assign w_xfer = (r_state == ST_GRANT) && !tx_busy_i && req_valid_i[r_ptr];

    // Next-state and combinational outputs; a transfer takes priority over a timeout in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = '0;
        tx_write_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) w_state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                req_ready_o[r_ptr] = !tx_busy_i;
                if (w_xfer)     w_state_nxt = ST_WRITE;
                else if (w_tmo) w_state_nxt = ST_IDLE;
            end
            ST_WRITE: begin
                tx_write_o  = 1'b1;
                w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                // busy is not yet visible here, so this cycle never looks at it
                w_state_nxt = r_last ? ST_IDLE : ST_GRANT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Owner, round-robin pointer and latched byte; pointer resets so requester 0 is scanned first
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ptr   <= IW'(N_REQ - 1);
            r_grant <= '0;
            r_val   <= '0;
            r_last  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_pick_vld) begin
                r_ptr   <= w_pick_idx;
                r_grant <= N_REQ'(1) << w_pick_idx;
            end else if ((r_state == ST_GAP && r_last) || w_tmo) begin
                r_grant <= '0;
            end
            if (w_xfer) begin
                r_val  <= req_data_i[{r_ptr, 3'b000} +: 8];
                r_last <= req_last_i[r_ptr];
            end
        end
    end

    assign grant_o  = r_grant;
    assign tx_val_o = r_val;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_tmo;

    // Fires on the TIMEOUT-th consecutive idle GRANT cycle with the transmitter free
    assign w_tmo = (r_state == ST_GRANT) && !tx_busy_i && !w_xfer && (r_cnt == CW'(TIMEOUT - 1));

    // Idle-grant counter and one-cycle revoke pulse; busy cycles neither count nor clear
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
            r_tmo <= 1'b0;
        end else begin
            r_tmo <= w_tmo;
            if (r_state != ST_GRANT || w_xfer || w_tmo) r_cnt <= '0;
            else if (!tx_busy_i)                       r_cnt <= r_cnt + 1'b1;
        end
    end

    assign timeout_o = r_tmo;
`else
    logic w_unused_cfg;

    assign w_tmo        = 1'b0;
    assign timeout_o    = 1'b0;
    assign w_unused_cfg = (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized message traffic against a round-robin message-order model.
// Requesters and the transmitter's busy line are emulated from per-requester byte queues; strobes are logged with cycle stamps.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that point and after inputs settle.
module tb_uart_tx_sched;
    localparam int N  = 3;
    localparam int TO = 4;

    logic           clk_i = 1'b0;
    logic           rstn_i;
    logic [N-1:0]   req_valid_i;
    logic [8*N-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic           tx_write_o;
    logic [7:0]     tx_val_o;
    logic           tx_busy_i;
    logic [N-1:0]   grant_o;
    logic           timeout_o;

    uart_tx_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_last_i(req_last_i), .req_ready_o(req_ready_o), .tx_write_o(tx_write_o),
        .tx_val_o(tx_val_o), .tx_busy_i(tx_busy_i), .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // environment state
    logic [8:0] bq [N][$];          // {last, data} per requester
    int         bubble [N];
    int         busy_lens [$];
    bit         busy_rand, bubble_en;
    int         busy_left;
    logic [N-1:0] xfer;
    // observations
    int obs_dat [$], obs_own [$], obs_cyc [$], tmo_cyc [$];
    logic [N-1:0] tmo_grant [$], grant_hist [$], ready_hist [$];
    bit write_hist [$];
    int viol_ready, viol_grant;
    bit env_expired;
    // model output
    int exp_dat [$], exp_own [$];

    function automatic int idx_of(input logic [N-1:0] g);
        int r;
        r = -1;
        for (int k = 0; k < N; k++) if (g[k]) r = k;
        return r;
    endfunction

    task automatic clear_obs();
        obs_dat.delete(); obs_own.delete(); obs_cyc.delete(); tmo_cyc.delete(); tmo_grant.delete();
        grant_hist.delete(); ready_hist.delete(); write_hist.delete();
        viol_ready = 0; viol_grant = 0; env_expired = 0;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0; req_valid_i = '0; req_data_i = '0; req_last_i = '0; tx_busy_i = 1'b0;
        for (int k = 0; k < N; k++) begin bq[k].delete(); bubble[k] = 0; end
        xfer = '0; busy_left = 0; busy_lens.delete(); busy_rand = 0; bubble_en = 0;
        clear_obs();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rstn_i = 1'b1;
    endtask

    // Message-level model: every requester holding bytes is waiting; each turn the first requester
    // with pending bytes after the previous winner sends one complete message.
    task automatic build_model();
        logic [8:0] mq [N][$];
        int ptr, win, cand;
        bit lst;
        exp_dat.delete(); exp_own.delete();
        for (int j = 0; j < N; j++) mq[j] = bq[j];
        ptr = N - 1;
        for (int turn = 0; turn < 1000; turn++) begin
            win = -1;
            for (int i = 1; i <= N; i++) begin
                cand = (ptr + i) % N;
                if (win < 0 && mq[cand].size() != 0) win = cand;
            end
            if (win < 0) break;
            lst = 1'b0;
            while (!lst && mq[win].size() != 0) begin
                exp_dat.push_back(int'(mq[win][0][7:0]));
                exp_own.push_back(win);
                lst = mq[win][0][8];
                void'(mq[win].pop_front());
            end
            ptr = win;
        end
    endtask

    // One loop iteration per clock cycle: consume last cycle's transfer, log outputs, drive busy and requesters.
    task automatic run_env(input int max_cyc, input bit until_idle, input bit stop_on_strobe);
        bit lst;
        int pend;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk_i); #1;
            for (int k = 0; k < N; k++) begin
                if (xfer[k] && bq[k].size() != 0) begin
                    lst = bq[k][0][8];
                    void'(bq[k].pop_front());
                    if (!lst && bubble_en) bubble[k] = int'($urandom_range(0, 2));
                end
            end
            xfer = '0;
            grant_hist.push_back(grant_o);
            write_hist.push_back(tx_write_o);
            if (timeout_o) begin tmo_cyc.push_back(cyc); tmo_grant.push_back(grant_o); end
            if (tx_write_o) begin
                obs_dat.push_back(int'(tx_val_o)); obs_own.push_back(idx_of(grant_o)); obs_cyc.push_back(cyc);
                if (busy_rand)                  busy_left = int'($urandom_range(0, 4));
                else if (busy_lens.size() != 0) busy_left = busy_lens.pop_front();
                else                            busy_left = 0;
                tx_busy_i = 1'b0;
                if (stop_on_strobe) return;
            end else if (busy_left > 0) begin
                tx_busy_i = 1'b1; busy_left--;
            end else begin
                tx_busy_i = 1'b0;
            end
            for (int k = 0; k < N; k++) begin
                if (bubble[k] > 0) begin
                    bubble[k]--; req_valid_i[k] = 1'b0;
                end else if (bq[k].size() != 0) begin
                    req_valid_i[k] = 1'b1; req_data_i[8*k +: 8] = bq[k][0][7:0]; req_last_i[k] = bq[k][0][8];
                end else begin
                    req_valid_i[k] = 1'b0;
                end
            end
            #1;
            ready_hist.push_back(req_ready_o);
            xfer = req_valid_i & req_ready_o;
            if ((req_ready_o & ~grant_o) != '0) viol_ready++;
            if (tx_busy_i && req_ready_o != '0) viol_ready++;
            if ($countones(grant_o) > 1) viol_grant++;
            pend = 0;
            for (int k = 0; k < N; k++) pend += bq[k].size();
            if (until_idle && pend == 0 && grant_o == '0 && busy_left == 0) return;
        end
        if (until_idle) env_expired = 1'b1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; req_valid_i = '1; req_data_i = '1; req_last_i = '0; tx_busy_i = 1'b0;
        #12;
        checks++; if (grant_o !== '0) begin failures++; $display("FAIL reset_grant got=%b want=0", grant_o); end
        checks++; if (req_ready_o !== '0) begin failures++; $display("FAIL reset_ready got=%b want=0", req_ready_o); end
        checks++; if (tx_write_o !== 1'b0) begin failures++; $display("FAIL reset_write got=%b want=0", tx_write_o); end
        checks++; if (tx_val_o !== 8'h00) begin failures++; $display("FAIL reset_val got=%h want=00", tx_val_o); end
        checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b want=0", timeout_o); end
    endtask

    task automatic test_single_byte();
        do_reset();
        bq[0].push_back({1'b1, 8'h41});
        run_env(5, 1'b0, 1'b0);
        checks++; if (grant_hist[0] !== 3'b000) begin failures++; $display("FAIL single_grant_c0 got=%b want=000", grant_hist[0]); end
        checks++; if (grant_hist[1] !== 3'b001) begin failures++; $display("FAIL single_grant_c1 got=%b want=001", grant_hist[1]); end
        checks++; if (ready_hist[1] !== 3'b001) begin failures++; $display("FAIL single_ready_c1 got=%b want=001", ready_hist[1]); end
        checks++; if (write_hist[1] !== 1'b0) begin failures++; $display("FAIL single_write_c1 got=%b want=0", write_hist[1]); end
        checks++; if (write_hist[2] !== 1'b1) begin failures++; $display("FAIL single_write_c2 got=%b want=1", write_hist[2]); end
        checks++; if (obs_dat.size() !== 1 || obs_dat[0] !== 'h41) begin failures++; $display("FAIL single_data strobes=%0d want=1 of 0x41", obs_dat.size()); end
        checks++; if (ready_hist[2] !== 3'b000 || ready_hist[3] !== 3'b000) begin failures++; $display("FAIL single_ready_wg got=%b/%b want=000/000", ready_hist[2], ready_hist[3]); end
        checks++; if (write_hist[3] !== 1'b0) begin failures++; $display("FAIL single_write_c3 got=%b want=0", write_hist[3]); end
        checks++; if (grant_hist[4] !== 3'b000) begin failures++; $display("FAIL single_grant_c4 got=%b want=000", grant_hist[4]); end
        checks++; if (tx_val_o !== 8'h41) begin failures++; $display("FAIL single_val_hold got=%h want=41", tx_val_o); end
    endtask

    task automatic test_contention();
        int ed [8];
        int eo [8];
        ed = '{'h10, 'h11, 'h20, 'h21, 'h30, 'h31, 'h40, 'h41};
        eo = '{0, 0, 1, 1, 0, 0, 1, 1};
        do_reset();
        bq[0].push_back({1'b0, 8'h10}); bq[0].push_back({1'b1, 8'h11});
        bq[0].push_back({1'b0, 8'h30}); bq[0].push_back({1'b1, 8'h31});
        bq[1].push_back({1'b0, 8'h20}); bq[1].push_back({1'b1, 8'h21});
        bq[1].push_back({1'b0, 8'h40}); bq[1].push_back({1'b1, 8'h41});
        run_env(200, 1'b1, 1'b0);
        checks++; if (env_expired !== 1'b0) begin failures++; $display("FAIL cont_done expired=%b want=0", env_expired); end
        checks++; if (obs_dat.size() !== 8) begin failures++; $display("FAIL cont_count got=%0d want=8", obs_dat.size()); end
        for (int i = 0; i < 8 && i < obs_dat.size(); i++) begin
            checks++;
            if (obs_dat[i] !== ed[i] || obs_own[i] !== eo[i]) begin
                failures++; $display("FAIL cont_byte%0d got=%h/req%0d want=%h/req%0d", i, obs_dat[i], obs_own[i], ed[i], eo[i]);
            end
        end
        if (obs_cyc.size() >= 3) begin
            checks++; if (obs_cyc[1] - obs_cyc[0] !== 3) begin failures++; $display("FAIL cont_gap_in got=%0d want=3", obs_cyc[1] - obs_cyc[0]); end
            checks++; if (obs_cyc[2] - obs_cyc[1] !== 4) begin failures++; $display("FAIL cont_gap_msg got=%0d want=4", obs_cyc[2] - obs_cyc[1]); end
        end
        checks++; if (viol_ready !== 0 || viol_grant !== 0) begin failures++; $display("FAIL cont_ready_rules ready=%0d grant=%0d want=0/0", viol_ready, viol_grant); end
    endtask

    task automatic test_backpressure();
        int s, rb;
        do_reset();
        busy_lens.push_back(20); busy_lens.push_back(0);
        bq[0].push_back({1'b0, 8'h61}); bq[0].push_back({1'b1, 8'h62});
        run_env(200, 1'b1, 1'b0);
        checks++; if (obs_dat.size() !== 2) begin failures++; $display("FAIL bp_count got=%0d want=2", obs_dat.size()); end
        if (obs_dat.size() == 2) begin
            checks++; if (obs_cyc[1] - obs_cyc[0] !== 22) begin failures++; $display("FAIL bp_spacing got=%0d want=22", obs_cyc[1] - obs_cyc[0]); end
            checks++; if (obs_dat[1] !== 'h62) begin failures++; $display("FAIL bp_data got=%h want=62", obs_dat[1]); end
        end
        s = -1;
        for (int j = 0; j < write_hist.size(); j++) if (s < 0 && write_hist[j]) s = j;
        rb = 0;
        for (int j = s + 1; j <= s + 20 && s >= 0 && j < ready_hist.size(); j++) if (ready_hist[j] != '0) rb++;
        checks++; if (s < 0 || rb !== 0) begin failures++; $display("FAIL bp_ready_busy got=%0d ready cycles want=0", rb); end
        checks++; if (viol_ready !== 0) begin failures++; $display("FAIL bp_ready_rules got=%0d want=0", viol_ready); end
    endtask

    task automatic test_timeout();
        int s;
        do_reset();
        bq[1].push_back({1'b0, 8'h55});
        run_env(2, 1'b0, 1'b0);
        bq[0].push_back({1'b1, 8'h77});
`ifdef UART_TX_SCHED_TIMEOUT_EN
        run_env(60, 1'b1, 1'b0);
        checks++; if (tmo_cyc.size() !== 1) begin failures++; $display("FAIL tmo_pulses got=%0d want=1", tmo_cyc.size()); end
        checks++; if (obs_dat.size() !== 2) begin failures++; $display("FAIL tmo_count got=%0d want=2", obs_dat.size()); end
        if (tmo_cyc.size() == 1 && obs_dat.size() == 2) begin
            s = obs_cyc[0];
            checks++; if (tmo_cyc[0] - s !== TO + 2) begin failures++; $display("FAIL tmo_when got=%0d want=%0d", tmo_cyc[0] - s, TO + 2); end
            checks++; if (tmo_grant[0] !== '0) begin failures++; $display("FAIL tmo_grant got=%b want=000", tmo_grant[0]); end
            checks++; if (obs_dat[1] !== 'h77 || obs_own[1] !== 0) begin failures++; $display("FAIL tmo_next got=%h/req%0d want=77/req0", obs_dat[1], obs_own[1]); end
            checks++; if (obs_cyc[1] - s !== TO + 4) begin failures++; $display("FAIL tmo_next_when got=%0d want=%0d", obs_cyc[1] - s, TO + 4); end
        end
`else
        run_env(40, 1'b0, 1'b0);
        checks++; if (tmo_cyc.size() !== 0) begin failures++; $display("FAIL hold_pulses got=%0d want=0", tmo_cyc.size()); end
        checks++; if (grant_o !== 3'b010) begin failures++; $display("FAIL hold_grant got=%b want=010", grant_o); end
        checks++; if (obs_dat.size() !== 1) begin failures++; $display("FAIL hold_count got=%0d want=1", obs_dat.size()); end
        bq[1].push_back({1'b1, 8'h56});
        run_env(100, 1'b1, 1'b0);
        checks++; if (obs_dat.size() !== 3) begin failures++; $display("FAIL hold_total got=%0d want=3", obs_dat.size()); end
        if (obs_dat.size() == 3) begin
            checks++; if (obs_dat[1] !== 'h56 || obs_own[1] !== 1) begin failures++; $display("FAIL hold_tail got=%h/req%0d want=56/req1", obs_dat[1], obs_own[1]); end
            checks++; if (obs_dat[2] !== 'h77 || obs_own[2] !== 0) begin failures++; $display("FAIL hold_next got=%h/req%0d want=77/req0", obs_dat[2], obs_own[2]); end
        end
`endif
    endtask

    task automatic test_reset_mid();
        int nz;
        do_reset();
        bq[1].push_back({1'b0, 8'hA1}); bq[1].push_back({1'b0, 8'hA2}); bq[1].push_back({1'b1, 8'hA3});
        run_env(20, 1'b0, 1'b1);
        checks++; if (tx_write_o !== 1'b1) begin failures++; $display("FAIL rmid_in_write got=%b want=1", tx_write_o); end
        rstn_i = 1'b0; req_valid_i = '0; tx_busy_i = 1'b0;
        #1;
        checks++; if (tx_write_o !== 1'b0 || grant_o !== '0) begin failures++; $display("FAIL rmid_async got=%b/%b want=0/000", tx_write_o, grant_o); end
        checks++; if (tx_val_o !== 8'h00 || req_ready_o !== '0) begin failures++; $display("FAIL rmid_clear got=%h/%b want=00/000", tx_val_o, req_ready_o); end
        for (int k = 0; k < N; k++) begin bq[k].delete(); bubble[k] = 0; end
        xfer = '0; busy_left = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rstn_i = 1'b1;
        clear_obs();
        run_env(20, 1'b0, 1'b0);
        nz = 0;
        foreach (grant_hist[j]) if (grant_hist[j] != '0) nz++;
        checks++; if (obs_dat.size() !== 0 || nz !== 0) begin failures++; $display("FAIL rmid_quiet strobes=%0d grants=%0d want=0/0", obs_dat.size(), nz); end
        bq[0].push_back({1'b1, 8'hB0}); bq[1].push_back({1'b1, 8'hB1});
        run_env(100, 1'b1, 1'b0);
        checks++;
        if (obs_dat.size() !== 2 || obs_dat[0] !== 'hB0 || obs_own[0] !== 0 || obs_dat[1] !== 'hB1) begin
            failures++; $display("FAIL rmid_restart strobes=%0d first=%h want=2 first=b0 from req0", obs_dat.size(), (obs_dat.size() != 0) ? obs_dat[0] : -1);
        end
    endtask

    task automatic test_random();
        int nm, len, bad, sp;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int k = 0; k < N; k++) begin
                nm = int'($urandom_range(0, 3));
                for (int m = 0; m < nm; m++) begin
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) bq[k].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                end
            end
            build_model();
            busy_rand = 1'b1; bubble_en = 1'b1;
            run_env(3000, 1'b1, 1'b0);
            checks++; if (env_expired !== 1'b0) begin failures++; $display("FAIL rnd%0d_done expired=%b want=0", r, env_expired); end
            checks++; if (obs_dat.size() !== exp_dat.size()) begin failures++; $display("FAIL rnd%0d_count got=%0d want=%0d", r, obs_dat.size(), exp_dat.size()); end
            bad = 0;
            for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) if (obs_dat[i] !== exp_dat[i] || obs_own[i] !== exp_own[i]) bad++;
            checks++; if (bad !== 0) begin failures++; $display("FAIL rnd%0d_order got=%0d wrong bytes want=0", r, bad); end
            sp = 0;
            for (int i = 1; i < obs_cyc.size(); i++) if (obs_cyc[i] - obs_cyc[i-1] < 3) sp++;
            checks++; if (sp !== 0) begin failures++; $display("FAIL rnd%0d_spacing got=%0d close pairs want=0", r, sp); end
            checks++; if (viol_ready !== 0 || viol_grant !== 0 || tmo_cyc.size() !== 0) begin
                failures++; $display("FAIL rnd%0d_rules ready=%0d grant=%0d tmo=%0d want=0/0/0", r, viol_ready, viol_grant, tmo_cyc.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_contention();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
